// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - instruction fetch controller between PC, instruction memory and decode
module ifetch_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    output logic        pcwrite_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    input  logic        id_stall_i,
    input  logic        flush_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t             state_q;
    logic [31:0]        addr_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic               drop_q;
    logic [31:0]        hold_data_q;
    logic [31:0]        hold_pc_q;

    // The output register can take a new instruction when empty or being consumed this cycle.
    logic free;
    logic wait_last;

    assign free      = !instr_valid_o || !id_stall_i;
    assign wait_last = (wait_cnt_q == CNT_W'(MAX_WAIT - 1));

    assign mem_req_o  = (state_q == S_BUSY) && !rst_i;
    assign mem_addr_o = addr_q;

    // PC advance: one pulse per committed instruction or per flush; a dropped ack never advances it.
    always_comb begin
        pcwrite_o = 1'b0;
        if (!rst_i) begin
            case (state_q)
                S_IDLE:  pcwrite_o = flush_i;
                S_BUSY:  pcwrite_o = flush_i || (mem_ack_i && !drop_q && free);
                S_HOLD:  pcwrite_o = flush_i || free;
                default: pcwrite_o = 1'b0;
            endcase
        end
    end

    // Fetch FSM with output register, hold register, drop flag and timeout counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            wait_cnt_q    <= '0;
            drop_q        <= 1'b0;
            hold_data_q   <= '0;
            hold_pc_q     <= '0;
            instr_o       <= '0;
            instr_pc_o    <= '0;
            instr_valid_o <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            // Decode took the instruction; a reload below overrides this.
            if (instr_valid_o && !id_stall_i) begin
                instr_valid_o <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (flush_i) begin
                        instr_valid_o <= 1'b0;
                    end else if (free) begin
                        addr_q     <= pc_i;
                        wait_cnt_q <= '0;
                        state_q    <= S_BUSY;
                    end
                end

                S_BUSY: begin
                    if (mem_ack_i) begin
                        state_q <= S_IDLE;
                        if (drop_q || flush_i) begin
                            drop_q <= 1'b0;
                            if (flush_i) begin
                                instr_valid_o <= 1'b0;
                            end
                        end else if (free) begin
                            instr_o       <= mem_data_i;
                            instr_pc_o    <= addr_q;
                            instr_valid_o <= 1'b1;
                        end else begin
                            hold_data_q <= mem_data_i;
                            hold_pc_q   <= addr_q;
                            state_q     <= S_HOLD;
                        end
                    end else begin
                        // The in-flight request cannot be cancelled, so its ack is dropped later.
                        if (flush_i) begin
                            instr_valid_o <= 1'b0;
                            drop_q        <= 1'b1;
                        end
                        if (wait_last) begin
                            state_q <= S_ERR;
                            err_o   <= 1'b1;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                        end
                    end
                end

                S_HOLD: begin
                    if (flush_i) begin
                        instr_valid_o <= 1'b0;
                        state_q       <= S_IDLE;
                    end else if (free) begin
                        instr_o       <= hold_data_q;
                        instr_pc_o    <= hold_pc_q;
                        instr_valid_o <= 1'b1;
                        state_q       <= S_IDLE;
                    end
                end

                default: begin
                    instr_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb/tb_ifetch_ctrl.sv - self-checking bench for ifetch_ctrl with a flag-based reference model
module tb_ifetch_ctrl;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        ack;
    logic [31:0] mdata;
    logic        stall;
    logic        flush;
    logic        pcwrite;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        err;

    always #5 clk = ~clk;

    ifetch_ctrl #(.MAX_WAIT(MW), .CNT_W(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .pc_i         (pc),
        .pcwrite_o    (pcwrite),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_ack_i    (ack),
        .mem_data_i   (mdata),
        .id_stall_i   (stall),
        .flush_i      (flush),
        .instr_o      (instr),
        .instr_pc_o   (instr_pc),
        .instr_valid_o(instr_valid),
        .err_o        (err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a request in flight, a parked response, a dead fetcher, plus the output slot.
    bit          in_flight, parked, dead, discard_next, slot_full;
    int          waited;
    logic [31:0] req_addr, slot_instr, slot_pc, park_instr, park_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        in_flight = 0; parked = 0; dead = 0; discard_next = 0; slot_full = 0;
        waited = 0; req_addr = 0; slot_instr = 0; slot_pc = 0; park_instr = 0; park_pc = 0;
    endtask

    task automatic model_check();
        bit room, exp_pcw;
        room    = !slot_full || !stall;
        exp_pcw = 0;
        if (!rst && !dead) begin
            if (flush)          exp_pcw = 1;
            else if (in_flight) exp_pcw = ack && !discard_next && room;
            else if (parked)    exp_pcw = room;
        end
        chk("mem_req",     {31'd0, mem_req},     {31'd0, in_flight && !rst});
        chk("pcwrite",     {31'd0, pcwrite},     {31'd0, exp_pcw});
        chk("mem_addr",    mem_addr,             req_addr);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, slot_full});
        chk("instr",       instr,                slot_instr);
        chk("instr_pc",    instr_pc,             slot_pc);
        chk("err",         {31'd0, err},         {31'd0, dead});
    endtask

    task automatic model_step();
        bit room, keep;
        room = !slot_full || !stall;
        keep = slot_full && stall;
        if (rst) begin
            model_reset();
            return;
        end
        if (dead) begin
            slot_full = 0;
            return;
        end
        if (in_flight) begin
            if (ack) begin
                in_flight = 0;
                if (discard_next || flush) begin
                    discard_next = 0;
                    if (flush) keep = 0;
                end else if (room) begin
                    slot_instr = mdata; slot_pc = req_addr; keep = 1;
                end else begin
                    park_instr = mdata; park_pc = req_addr; parked = 1;
                end
            end else begin
                if (flush) begin
                    keep = 0; discard_next = 1;
                end
                if (waited + 1 >= MW) begin
                    in_flight = 0; dead = 1;
                end else begin
                    waited++;
                end
            end
        end else if (parked) begin
            if (flush) begin
                keep = 0; parked = 0;
            end else if (room) begin
                slot_instr = park_instr; slot_pc = park_pc; keep = 1; parked = 0;
            end
        end else begin
            if (flush) begin
                keep = 0;
            end else if (room) begin
                req_addr = pc; waited = 0; in_flight = 1;
            end
        end
        slot_full = keep;
    endtask

    task automatic tick();
        #2;
        model_check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit r, input logic [31:0] p, input bit a, input logic [31:0] d,
                         input bit s, input bit f);
        rst = r; pc = p; ack = a; mdata = d; stall = s; flush = f;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        model_reset();
        #1;
        tick();
        chk("reset_valid", {31'd0, instr_valid}, 32'd0);
        chk("reset_err",   {31'd0, err},         32'd0);

        // Sequential fetch from address 0.
        drive(0, 32'h0, 0, 0, 0, 0);
        tick();
        drive(0, 32'h0, 1, 32'h2008_0005, 0, 0);
        tick();
        chk("seq_instr",    instr,    32'h2008_0005);
        chk("seq_instr_pc", instr_pc, 32'h0);

        // Decode stall holds the output register and blocks the next request.
        drive(0, 32'h4, 0, 0, 1, 0);
        tick();
        tick();
        chk("stall_instr", instr, 32'h2008_0005);
        drive(0, 32'h4, 0, 0, 0, 0);
        tick();
        drive(0, 32'h4, 1, 32'hAABB_CCDD, 0, 0);
        tick();
        chk("stall_release", instr, 32'hAABB_CCDD);

        // Flush while a request is in flight: the late ack is dropped.
        drive(0, 32'h10, 0, 0, 0, 0);
        tick();
        drive(0, 32'h40, 0, 0, 0, 1);
        tick();
        drive(0, 32'h40, 1, 32'hDEAD_BEEF, 0, 0);
        tick();
        chk("drop_valid", {31'd0, instr_valid}, 32'd0);
        drive(0, 32'h40, 0, 0, 0, 0);
        tick();
        chk("redirect_addr", mem_addr, 32'h40);

        // Flush coincident with ack.
        drive(0, 32'h44, 1, 32'h1234_5678, 0, 1);
        tick();
        chk("flush_ack_valid", {31'd0, instr_valid}, 32'd0);

        // Timeout after MW cycles without ack, then flush is ignored and reset clears it.
        drive(0, 32'h50, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < MW; i++) tick();
        chk("timeout_err", {31'd0, err}, 32'd1);
        drive(0, 32'h50, 0, 0, 0, 1);
        tick();
        drive(1, 32'h0, 0, 0, 0, 0);
        tick();
        chk("timeout_cleared", {31'd0, err}, 32'd0);

        // Reset while busy; an ack arriving afterwards is ignored.
        drive(0, 32'h80, 0, 0, 0, 0);
        tick();
        drive(1, 32'h80, 0, 0, 0, 0);
        tick();
        drive(0, 32'h80, 1, 32'hCAFE_F00D, 0, 0);
        tick();
        chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
        chk("late_ack_instr", instr, 32'h0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 59) == 0,
                  $urandom & 32'hFFFF_FFFC,
                  in_flight ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0),
                  $urandom,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
